// File: rtl/fdc_sd_arbiter.sv
// Round-robin arbiter sharing one SD block channel between NUM_REQ floppy controllers.
// Optional REQ-phase watchdog enabled by defining FDC_SD_ARB_TIMEOUT_EN.
module fdc_sd_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter logic [23:0] TIMEOUT_CYC = 24'd5000000
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [31:0]        req_lba      [NUM_REQ],
    input  logic [NUM_REQ-1:0] req_rd,
    input  logic [NUM_REQ-1:0] req_wr,
    output logic [NUM_REQ-1:0] req_ack,
    input  logic [7:0]         req_buff_din [NUM_REQ],
    output logic [31:0]        host_lba,
    output logic               host_rd,
    output logic               host_wr,
    input  logic               host_ack,
    output logic [7:0]         host_buff_din,
    output logic [1:0]         grant,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {StIdle, StReq, StXfer, StDone} state_e;

    state_e      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [31:0] lba_q, lba_d;
    logic        dir_rd_q, dir_rd_d;
    logic        ack_prev_q;
    logic        ack_rise;

    logic [3:0]  pend4;
    logic [3:0]  rd4;
    logic        pick_valid;
    logic [1:0]  pick_idx;
    logic [1:0]  idx;

`ifdef FDC_SD_ARB_TIMEOUT_EN
    logic [23:0] cnt_q;
    logic        terr_q, terr_d;
`else
    logic        unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    assign pend4    = 4'(req_rd | req_wr);
    assign rd4      = 4'(req_rd);
    // Only a fresh rise counts, so an ack left high from a previous transfer is ignored.
    assign ack_rise = host_ack & ~ack_prev_q;

    // Lowest offset from last_grant+1 wins: iterate downward so it is assigned last.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = 2'((32'(last_grant_q) + unsigned'(k)) % NUM_REQ);
            if (pend4[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        lba_d        = lba_q;
        dir_rd_d     = dir_rd_q;
`ifdef FDC_SD_ARB_TIMEOUT_EN
        terr_d       = terr_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d  = pick_idx;
                    lba_d    = req_lba[pick_idx];
                    dir_rd_d = rd4[pick_idx];
                    state_d  = StReq;
                end
            end
            StReq: begin
                if (ack_rise) begin
                    state_d = StXfer;
                end else if (!pend4[grant_q]) begin
                    state_d = StIdle;
`ifdef FDC_SD_ARB_TIMEOUT_EN
                end else if (cnt_q == TIMEOUT_CYC - 24'd1) begin
                    state_d      = StIdle;
                    last_grant_d = grant_q;
                    terr_d       = 1'b1;
`endif
                end
            end
            StXfer: begin
                if (!host_ack) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                last_grant_d = grant_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= 2'(NUM_REQ - 1);
            lba_q        <= '0;
            dir_rd_q     <= 1'b0;
            ack_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            lba_q        <= lba_d;
            dir_rd_q     <= dir_rd_d;
            ack_prev_q   <= host_ack;
        end
    end

`ifdef FDC_SD_ARB_TIMEOUT_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_q  <= '0;
            terr_q <= 1'b0;
        end else begin
            terr_q <= terr_d;
            if (state_q == StReq) begin
                cnt_q <= cnt_q + 24'd1;
            end else begin
                cnt_q <= '0;
            end
        end
    end
    assign timeout_err = terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        req_ack = '0;
        if (state_q == StXfer) begin
            req_ack[grant_q] = host_ack;
        end
    end

    assign host_rd       = (state_q == StReq) & dir_rd_q;
    assign host_wr       = (state_q == StReq) & ~dir_rd_q;
    assign host_lba      = lba_q;
    assign host_buff_din = req_buff_din[grant_q];
    assign grant         = grant_q;
    assign busy          = (state_q != StIdle);

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Directed self-checking bench for fdc_sd_arbiter; timeout scenario runs only when
// FDC_SD_ARB_TIMEOUT_EN is defined.
module tb_fdc_sd_arbiter;

    logic        CLK;
    logic        RESET_N;
    logic [31:0] req_lba      [4];
    logic [3:0]  req_rd;
    logic [3:0]  req_wr;
    logic [3:0]  req_ack;
    logic [7:0]  req_buff_din [4];
    logic [31:0] host_lba;
    logic        host_rd;
    logic        host_wr;
    logic        host_ack;
    logic [7:0]  host_buff_din;
    logic [1:0]  grant;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    fdc_sd_arbiter #(
        .NUM_REQ    (4),
        .TIMEOUT_CYC(24'd100)
    ) dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .req_lba      (req_lba),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_ack      (req_ack),
        .req_buff_din (req_buff_din),
        .host_lba     (host_lba),
        .host_rd      (host_rd),
        .host_wr      (host_wr),
        .host_ack     (host_ack),
        .host_buff_din(host_buff_din),
        .grant        (grant),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset;
        RESET_N  = 1'b0;
        req_rd   = '0;
        req_wr   = '0;
        host_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_lba[i]      = '0;
            req_buff_din[i] = '0;
        end
        repeat (2) @(posedge CLK);
        #1;
        RESET_N = 1'b1;
    endtask

    // Host acks; the granted requester drops its level when it sees its ack.
    task automatic do_xfer(input int hold);
        logic [3:0] mask;
        host_ack = 1'b1;
        step();
        mask   = req_ack;
        req_rd = req_rd & ~mask;
        req_wr = req_wr & ~mask;
        repeat (hold - 1) step();
        host_ack = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if ({host_rd, host_wr, req_ack, grant, busy, timeout_err} !== 10'b0 || host_lba !== 32'h0) begin
            errors++;
            $display("FAIL reset: rd=%b wr=%b ack=%b grant=%0d busy=%b terr=%b lba=%h want all 0",
                     host_rd, host_wr, req_ack, grant, busy, timeout_err, host_lba);
        end
    endtask

    task automatic test_single_read;
        apply_reset();
        req_rd     = 4'b0001;
        req_lba[0] = 32'h12;
        step();
        checks++;
        if (host_rd !== 1'b1 || host_wr !== 1'b0 || host_lba !== 32'h12 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_req: rd=%b wr=%b lba=%h busy=%b want 1 0 00000012 1",
                     host_rd, host_wr, host_lba, busy);
        end
        host_ack = 1'b1;
        step();
        checks++;
        if (req_ack !== 4'b0001 || host_rd !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: req_ack=%b rd=%b want 0001 0", req_ack, host_rd);
        end
        req_rd = 4'b0000;
        repeat (19) step();
        checks++;
        if (req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL single_ack_hold: req_ack=%b want 0001", req_ack);
        end
        host_ack = 1'b0;
        #1;
        checks++;
        if (req_ack !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_ack_fall: req_ack=%b busy=%b want 0000 1", req_ack, busy);
        end
        step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_done: busy=%b want 1", busy);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: busy=%b want 0", busy);
        end
    endtask

    task automatic test_round_robin;
        int exp2 [2] = '{0, 2};
        apply_reset();
        req_rd = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (grant !== 2'(i) || host_rd !== 1'b1) begin
                errors++;
                $display("FAIL rr_all[%0d]: grant=%0d rd=%b want %0d 1", i, grant, host_rd, i);
            end
            do_xfer(3);
        end
        req_rd = 4'b0101;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (grant !== 2'(exp2[i]) || host_rd !== 1'b1) begin
                errors++;
                $display("FAIL rr_0101[%0d]: grant=%0d rd=%b want %0d 1", i, grant, host_rd, exp2[i]);
            end
            do_xfer(2);
        end
    endtask

    task automatic test_rw_conflict;
        apply_reset();
        req_rd = 4'b0100;
        req_wr = 4'b0100;
        step();
        checks++;
        if (host_rd !== 1'b1 || host_wr !== 1'b0 || grant !== 2'd2) begin
            errors++;
            $display("FAIL rw_conflict: rd=%b wr=%b grant=%0d want 1 0 2", host_rd, host_wr, grant);
        end
        do_xfer(2);
    endtask

    task automatic test_buff_lba_hold;
        apply_reset();
        req_wr          = 4'b0010;
        req_lba[1]      = 32'hABCD0001;
        req_lba[0]      = 32'h00000055;
        req_buff_din[1] = 8'hA5;
        req_buff_din[0] = 8'h3C;
        step();
        checks++;
        if (host_wr !== 1'b1 || host_rd !== 1'b0 || grant !== 2'd1 || host_buff_din !== 8'hA5) begin
            errors++;
            $display("FAIL buff_req: wr=%b rd=%b grant=%0d din=%h want 1 0 1 a5",
                     host_wr, host_rd, grant, host_buff_din);
        end
        host_ack = 1'b1;
        step();
        req_lba[1] = 32'hDEADBEEF;
        req_rd     = 4'b0001;
        #1;
        checks++;
        if (host_lba !== 32'hABCD0001 || host_buff_din !== 8'hA5 || req_ack !== 4'b0010) begin
            errors++;
            $display("FAIL lba_hold: lba=%h din=%h ack=%b want abcd0001 a5 0010",
                     host_lba, host_buff_din, req_ack);
        end
        host_ack = 1'b0;
        req_wr   = 4'b0000;
        step();
        step();
        step();
        checks++;
        if (grant !== 2'd0 || host_rd !== 1'b1 || host_lba !== 32'h55 || host_buff_din !== 8'h3C) begin
            errors++;
            $display("FAIL queued_req: grant=%0d rd=%b lba=%h din=%h want 0 1 00000055 3c",
                     grant, host_rd, host_lba, host_buff_din);
        end
        do_xfer(2);
    endtask

    task automatic test_abort;
        apply_reset();
        req_wr = 4'b0010;
        step();
        checks++;
        if (host_wr !== 1'b1 || grant !== 2'd1) begin
            errors++;
            $display("FAIL abort_req: wr=%b grant=%0d want 1 1", host_wr, grant);
        end
        req_wr = 4'b0000;
        step();
        checks++;
        if (host_wr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: wr=%b busy=%b want 0 0", host_wr, busy);
        end
        // last_grant must still be 3, so requester 0 beats requester 2.
        req_rd = 4'b0101;
        step();
        checks++;
        if (grant !== 2'd0 || host_rd !== 1'b1) begin
            errors++;
            $display("FAIL abort_last_grant: grant=%0d rd=%b want 0 1", grant, host_rd);
        end
        req_rd = 4'b0000;
        step();
    endtask

    task automatic test_stale_ack;
        apply_reset();
        host_ack = 1'b1;
        req_rd   = 4'b0001;
        repeat (4) step();
        checks++;
        if (host_rd !== 1'b1 || req_ack !== 4'b0000) begin
            errors++;
            $display("FAIL stale_ack: rd=%b ack=%b want 1 0000", host_rd, req_ack);
        end
        host_ack = 1'b0;
        step();
        host_ack = 1'b1;
        step();
        checks++;
        if (host_rd !== 1'b0 || req_ack !== 4'b0001) begin
            errors++;
            $display("FAIL fresh_ack: rd=%b ack=%b want 0 0001", host_rd, req_ack);
        end
        req_rd   = 4'b0000;
        host_ack = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset_mid_xfer;
        apply_reset();
        req_rd     = 4'b0100;
        req_lba[2] = 32'h0000BEEF;
        step();
        host_ack = 1'b1;
        step();
        checks++;
        if (req_ack !== 4'b0100 || grant !== 2'd2) begin
            errors++;
            $display("FAIL pre_reset_xfer: ack=%b grant=%0d want 0100 2", req_ack, grant);
        end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({host_rd, host_wr, req_ack, grant, busy, timeout_err} !== 10'b0 || host_lba !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: rd=%b wr=%b ack=%b grant=%0d busy=%b lba=%h want all 0",
                     host_rd, host_wr, req_ack, grant, busy, host_lba);
        end
        apply_reset();
    endtask

`ifdef FDC_SD_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int n;
        apply_reset();
        req_rd = 4'b0011;
        step();
        n = 0;
        while (host_rd === 1'b1 && n < 200) begin
            n++;
            step();
        end
        checks++;
        if (n !== 100) begin
            errors++;
            $display("FAIL timeout_len: rd high %0d cycles want 100", n);
        end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flag: terr=%b busy=%b want 1 0", timeout_err, busy);
        end
        step();
        checks++;
        if (grant !== 2'd1 || host_rd !== 1'b1 || timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_next: grant=%0d rd=%b terr=%b want 1 1 1", grant, host_rd, timeout_err);
        end
        apply_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_rw_conflict();
        test_buff_lba_hold();
        test_abort();
        test_stale_ack();
        test_reset_mid_xfer();
`ifdef FDC_SD_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
